if_fetch: RTL and testbench

Instruction fetch stage: the producer side of the IF/ID valid / ready_go / allow_in handshake. It owns the fetch PC and issues requests to instruction memory, which answers with variable latency and accepts at most one outstanding request. It presents one instruction at a time to if_id on pc_if / instruction_if / valid_if / ready_go_if. It redirects on flush and discards stale memory responses. It sits between the imem port and if_id.

---
 rtl/if_fetch_if.sv | 32 +++
 rtl/if_fetch.sv | 115 +++++++++++
 tb/tb_if_fetch.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// IF-stage bundle: instruction-memory request/response port plus the
// IF->ID presentation signals, with a flush redirect from the pipeline.
interface if_fetch_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic [BUS_WIDTH-1:0]  flush_pc;
  logic                  imem_req;
  logic [BUS_WIDTH-1:0]  imem_addr;
  logic                  imem_ready;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  allow_in_id;
  logic                  valid_if;
  logic                  ready_go_if;
  logic [BUS_WIDTH-1:0]  pc_if;
  logic [DATA_WIDTH-1:0] instruction_if;

  // Handshakes: a memory request transfers when imem_req & imem_ready; an
  // instruction transfers to if_id when valid_if & ready_go_if & allow_in_id
  // and no flush is present in that cycle.
  modport master (
    input  flush, flush_pc, imem_ready, imem_rvalid, imem_rdata, allow_in_id,
    output imem_req, imem_addr, valid_if, ready_go_if, pc_if, instruction_if
  );

  modport slave (
    output flush, flush_pc, imem_ready, imem_rvalid, imem_rdata, allow_in_id,
    input  imem_req, imem_addr, valid_if, ready_go_if, pc_if, instruction_if
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one request in
// flight to imem, and presents one instruction at a time to if_id.
module if_fetch #(
  parameter int                   BUS_WIDTH  = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus,
  output logic [1:0] dbg_state
);

  localparam logic [BUS_WIDTH-1:0] PC_STEP = BUS_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_LIVE  = 2'd1,
    REQ_STALE = 2'd2
  } req_state_e;

  req_state_e            state;
  logic [BUS_WIDTH-1:0]  fetch_pc;
  logic [BUS_WIDTH-1:0]  req_pc;
  logic                  buf_valid;
  logic [BUS_WIDTH-1:0]  buf_pc;
  logic [DATA_WIDTH-1:0] buf_instr;

  logic                  outstanding;
  logic                  in_flight;
  logic                  live_rsp;
  logic                  valid;
  logic                  ready_go;
  logic                  fire;
  logic                  empty_next;
  logic                  req;
  logic                  accept;
  logic [BUS_WIDTH-1:0]  addr;
  logic [BUS_WIDTH-1:0]  pc_out;
  logic [DATA_WIDTH-1:0] instr_out;

  assign outstanding = (state != REQ_IDLE);
  assign in_flight   = (state == REQ_LIVE);
  assign live_rsp    = in_flight & bus.imem_rvalid;

  assign valid    = buf_valid | in_flight;
  assign ready_go = buf_valid | live_rsp;
  assign fire     = valid & ready_go & bus.allow_in_id & ~bus.flush;

  // The stage holds nothing undelivered after this cycle when it hands off,
  // is redirected, or was already empty (a stale in-flight does not count).
  assign empty_next = bus.flush | fire | ~valid;
  assign req        = ~rst & (~outstanding | bus.imem_rvalid) & empty_next;
  assign addr       = bus.flush ? bus.flush_pc : fetch_pc;
  assign accept     = req & bus.imem_ready;

  always_comb begin
    pc_out    = '0;
    instr_out = '0;
    if (buf_valid) begin
      pc_out    = buf_pc;
      instr_out = buf_instr;
    end else if (live_rsp) begin
      pc_out    = req_pc;
      instr_out = bus.imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ_IDLE;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else begin
      if (accept) begin
        state    <= REQ_LIVE;
        req_pc   <= addr;
        fetch_pc <= addr + PC_STEP;
      end else begin
        // A response (live or stale) frees the port; a flush over an
        // unanswered request marks that response as stale.
        if (outstanding & bus.imem_rvalid) begin
          state <= REQ_IDLE;
        end else if (outstanding & bus.flush) begin
          state <= REQ_STALE;
        end
        if (bus.flush) begin
          fetch_pc <= bus.flush_pc;
        end
      end

      if (bus.flush) begin
        buf_valid <= 1'b0;
      end else if (live_rsp & ~fire) begin
        buf_valid <= 1'b1;
        buf_pc    <= req_pc;
        buf_instr <= bus.imem_rdata;
      end else if (fire & buf_valid) begin
        buf_valid <= 1'b0;
      end
    end
  end

  assign bus.imem_req       = req;
  assign bus.imem_addr      = addr;
  assign bus.valid_if       = valid;
  assign bus.ready_go_if    = ready_go;
  assign bus.pc_if          = pc_out;
  assign bus.instruction_if = instr_out;
  assign dbg_state          = state;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a cycle table, hand-written multi-cycle sequences and a
// randomized run checked against a program-order stream model.
module tb_if_fetch;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  if_fetch_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) bus ();
  if_fetch_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  if_fetch #(.BUS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  if_fetch #(.BUS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg_state2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model / bookkeeping ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          cyc;
  int          mem_lat;
  bit          rand_lat;
  logic        s_acc;
  logic        s_fire;
  logic [31:0] s_addr;

  int n_checks;
  int n_fail;

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_mem();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = f(pend[0].addr);
      void'(pend.pop_front());
    end
  endtask

  task automatic sample();
    @(negedge clk);
    s_acc  = bus.imem_req & bus.imem_ready;
    s_addr = bus.imem_addr;
    s_fire = bus.valid_if & bus.ready_go_if & bus.allow_in_id & ~bus.flush;
  endtask

  task automatic advance();
    pend_t p;
    if (s_acc) begin
      p.addr = s_addr;
      p.due  = cyc + (rand_lat ? int'($urandom_range(1, 4)) : mem_lat);
      pend.push_back(p);
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset(input bit clear_mem);
    rst = 1'b1;
    sample(); advance();
    sample(); advance();
    rst = 1'b0;
    if (clear_mem) begin
      pend.delete();
      bus.imem_rvalid = 1'b0;
    end
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ready;
    logic        allow;
    logic        e_req;
    logic [31:0] e_addr;
    logic        care_v;
    logic        e_valid;
    logic        e_rg;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[11];

  // ---------------- scoreboard for the random run ----------------
  logic [31:0] exp_q[$];
  logic [31:0] next_fetch;
  logic [31:0] ea;
  logic [31:0] e;
  int          undeliv;
  int          delivered;
  bit          seen;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    mem_lat  = 1;
    rand_lat = 1'b0;
    rst      = 1'b1;
    bus.flush = 1'b0;  bus.flush_pc = '0;  bus.imem_ready = 1'b1;
    bus.allow_in_id = 1'b1;  bus.imem_rvalid = 1'b0;  bus.imem_rdata = '0;
    bus2.flush = 1'b0; bus2.flush_pc = '0; bus2.imem_ready = 1'b1;
    bus2.allow_in_id = 1'b1; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;

    // Stream, 3-cycle downstream stall on 0x4, then flush on the 0xC response.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h4,   1'b1, 1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h8,   1'b1, 1'b1, 1'b1, 32'h4};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h8,   1'b1, 1'b1, 1'b1, 32'h4};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h8,   1'b1, 1'b1, 1'b1, 32'h4};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h8,   1'b1, 1'b1, 1'b1, 32'h4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'hC,   1'b1, 1'b1, 1'b1, 32'h8};
    vecs[8]  = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 32'hC};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h204, 1'b1, 1'b1, 1'b1, 32'h200};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h208, 1'b1, 1'b1, 1'b1, 32'h204};

    @(posedge clk);
    #1;
    drive_mem();
    do_reset(1'b1);

    for (int i = 0; i < 11; i++) begin
      rst             = vecs[i].rst;
      bus.flush       = vecs[i].flush;
      bus.flush_pc    = vecs[i].flush_pc;
      bus.imem_ready  = vecs[i].ready;
      bus.allow_in_id = vecs[i].allow;
      sample();
      if (i == 0) check("reset_state_idle", 32'(dbg_state), 32'h0);
      check($sformatf("t%0d_req", i),   32'(bus.imem_req),    32'(vecs[i].e_req));
      check($sformatf("t%0d_addr", i),  bus.imem_addr,        vecs[i].e_addr);
      if (vecs[i].care_v)
        check($sformatf("t%0d_valid", i), 32'(bus.valid_if),  32'(vecs[i].e_valid));
      check($sformatf("t%0d_rg", i),    32'(bus.ready_go_if), 32'(vecs[i].e_rg));
      check($sformatf("t%0d_pc", i),    bus.pc_if,            vecs[i].e_pc);
      check($sformatf("t%0d_instr", i), bus.instruction_if,
            vecs[i].e_rg ? f(vecs[i].e_pc) : 32'h0);
      advance();
    end
    bus.flush = 1'b0;

    // 3-cycle memory, flush to 0x100 one cycle after the 0x8 request;
    // the second instance checks the 0xFFFFFFFC -> 0x0 wrap meanwhile.
    do_reset(1'b1);
    mem_lat = 3;
    bus.allow_in_id = 1'b1;
    bus.imem_ready  = 1'b1;
    sample();
    check("b_first_req", 32'(bus.imem_req), 32'h1);
    check("b_first_addr", bus.imem_addr, 32'h0);
    check("wrap_first_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    check("wrap_first_req", 32'(bus2.imem_req), 32'h1);
    advance();
    bus2.imem_rvalid = 1'b1;
    bus2.imem_rdata  = f(32'hFFFF_FFFC);
    sample();
    check("wrap_pc", bus2.pc_if, 32'hFFFF_FFFC);
    check("wrap_next_addr", bus2.imem_addr, 32'h0);
    check("wrap_next_req", 32'(bus2.imem_req), 32'h1);
    check("b_wait_rg", 32'(bus.ready_go_if), 32'h0);
    advance();
    bus2.imem_rvalid = 1'b0;
    sample(); advance();
    sample();
    check("b_pc0_rg", 32'(bus.ready_go_if), 32'h1);
    check("b_pc0", bus.pc_if, 32'h0);
    advance();
    sample(); advance();
    sample(); advance();
    sample();
    check("b_pc4", bus.pc_if, 32'h4);
    check("b_req8_addr", bus.imem_addr, 32'h8);
    check("b_req8", 32'(s_acc), 32'h1);
    advance();
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h100;
    sample();
    check("b_flush_no_req", 32'(bus.imem_req), 32'h0);
    advance();
    bus.flush = 1'b0;
    sample();
    check("b_stale_valid", 32'(bus.valid_if), 32'h0);
    check("b_stale_no_req", 32'(bus.imem_req), 32'h0);
    advance();
    sample();
    check("b_stale_not_presented", 32'(bus.ready_go_if), 32'h0);
    check("b_redirect_req", 32'(bus.imem_req), 32'h1);
    check("b_redirect_addr", bus.imem_addr, 32'h100);
    advance();
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      sample();
      if (bus.ready_go_if) begin
        seen = 1'b1;
        check("b_redirect_pc", bus.pc_if, 32'h100);
        check("b_redirect_instr", bus.instruction_if, f(32'h100));
      end
      advance();
    end
    check("b_redirect_arrived", 32'(seen), 32'h1);

    // imem_ready low for 4 cycles: request and address held, nothing in flight.
    do_reset(1'b1);
    mem_lat = 1;
    bus.imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      check($sformatf("c%0d_req_held", k), 32'(bus.imem_req), 32'h1);
      check($sformatf("c%0d_addr_held", k), bus.imem_addr, 32'h0);
      check($sformatf("c%0d_valid", k), 32'(bus.valid_if), 32'h0);
      advance();
    end
    bus.imem_ready = 1'b1;
    sample();
    check("c_accept", 32'(s_acc), 32'h1);
    advance();
    sample();
    check("c_pc0_rg", 32'(bus.ready_go_if), 32'h1);
    check("c_pc0", bus.pc_if, 32'h0);
    advance();

    // rst while a request is in flight; its late response must be ignored.
    do_reset(1'b1);
    mem_lat = 3;
    sample(); advance();
    rst = 1'b1;
    sample();
    check("d_rst_no_req", 32'(bus.imem_req), 32'h0);
    advance();
    sample();
    advance();
    rst = 1'b0;
    bus.imem_ready = 1'b0;
    sample();
    check("d_after_rst_valid", 32'(bus.valid_if), 32'h0);
    check("d_late_rsp_rg", 32'(bus.ready_go_if), 32'h0);
    check("d_late_rsp_pc", bus.pc_if, 32'h0);
    check("d_late_rsp_instr", bus.instruction_if, 32'h0);
    check("d_restart_addr", bus.imem_addr, 32'h0);
    advance();
    bus.imem_ready = 1'b1;
    sample();
    check("d_restart_req", 32'(bus.imem_req), 32'h1);
    advance();
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      sample();
      if (bus.ready_go_if) begin
        seen = 1'b1;
        check("d_restart_pc", bus.pc_if, 32'h0);
      end
      advance();
    end
    check("d_restart_arrived", 32'(seen), 32'h1);

    // Randomized run: delivered PCs must follow program order from the last
    // redirect, requests must go to the next program address, and at most
    // one accepted, unkilled instruction may be undelivered.
    do_reset(1'b1);
    rand_lat   = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h0);
    next_fetch = 32'h0;
    undeliv    = 0;
    delivered  = 0;
    for (int k = 0; k < 800; k++) begin
      bus.flush       = ($urandom_range(0, 99) < 5);
      bus.flush_pc    = 32'($urandom) & 32'hFFFF_FFFC;
      bus.allow_in_id = ($urandom_range(0, 99) < 70);
      bus.imem_ready  = ($urandom_range(0, 99) < 75);
      sample();
      ea = bus.flush ? bus.flush_pc : next_fetch;
      if (s_fire) begin
        e = exp_q.pop_front();
        check("rnd_pc", bus.pc_if, e);
        check("rnd_instr", bus.instruction_if, f(e));
        exp_q.push_back(e + 32'h4);
        undeliv--;
        delivered++;
      end
      if (bus.flush) begin
        exp_q.delete();
        exp_q.push_back(bus.flush_pc);
        next_fetch = bus.flush_pc;
        undeliv    = 0;
      end
      if (s_acc) begin
        check("rnd_addr", bus.imem_addr, ea);
        next_fetch = ea + 32'h4;
        undeliv++;
        check("rnd_one_undelivered", 32'(undeliv <= 1), 32'h1);
      end
      advance();
    end
    bus.flush = 1'b0;
    check("rnd_progress", 32'(delivered > 40), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
